// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer controllers.
//   - DEFAULT_ADDRESS_BITS / DEFAULT_SYNC_STAGES : default geometry
//   - bin2gray / gray2bin : width-agnostic code conversions. They operate on a
//     32-bit container. Callers zero-extend the input and size-cast the result
//     to their own pointer width. Both conversions are exact for any width up
//     to 32 bits, provided the unused upper bits are zero.
// Used by both the write-side and read-side controllers.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_ADDRESS_BITS = 3;
  localparam int DEFAULT_SYNC_STAGES  = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// -----------------------------------------------------------------------------
// ptr_sync
// Generic multi-flop bus synchroniser. It is meant for Gray-coded pointers,
// where at most one bit changes per update, so a bus-wide capture is safe.
// Ports:
//   clk_i  destination-domain clock (rising edge)
//   rst_i  asynchronous active-high reset; every stage clears to 0
//   d_i    WIDTH-bit bus from the foreign domain
//   q_o    output of the last of STAGES flops
// -----------------------------------------------------------------------------
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_ctrl
// Write-side pointer controller for the asynchronous FIFO. It runs entirely in
// the write clock domain.
// Ports:
//   W_CLK          write clock
//   W_RST          asynchronous active-high reset
//   WINC           write request
//   W_RPTR_ASYNC   read-domain Gray pointer (unsynchronised)
//   OVF_CLR        clears W_OVERFLOW (a simultaneous set wins)
//   W_EN           memory write enable = WINC & ~W_FULL
//   W_ADDRESS      memory write address (binary pointer LSBs)
//   W_PTR          registered Gray write pointer, sent to the read side
//   W_FULL         registered full flag
//   W_ALMOST_FULL  registered, level >= ALMOST_FULL_TH
//   W_LEVEL        registered conservative fill level, 0..depth
//   W_OVERFLOW     sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRESS_BITS   = DEFAULT_ADDRESS_BITS,
  parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int ALMOST_FULL_TH = 2**ADDRESS_BITS - 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  WINC,
  input  logic [ADDRESS_BITS:0] W_RPTR_ASYNC,
  input  logic                  OVF_CLR,
  output logic                  W_EN,
  output logic [ADDRESS_BITS-1:0] W_ADDRESS,
  output logic [ADDRESS_BITS:0] W_PTR,
  output logic                  W_FULL,
  output logic                  W_ALMOST_FULL,
  output logic [ADDRESS_BITS:0] W_LEVEL,
  output logic                  W_OVERFLOW
);

  // Pointers carry one extra wrap bit beyond the address.
  localparam int PW = ADDRESS_BITS + 1;
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] rq_gray;
  logic [PW-1:0] rbin;
  logic          w_en;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i (W_CLK),
    .rst_i (W_RST),
    .d_i   (W_RPTR_ASYNC),
    .q_o   (rq_gray)
  );

  assign w_en = WINC & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + {{ADDRESS_BITS{1'b0}}, w_en};
    wgray_d = PW'(bin2gray(32'(wbin_d)));
    rbin    = PW'(gray2bin(32'(rq_gray)));
    // The synchronised read pointer lags the true one. The level computed
    // from it can only over-estimate occupancy, which keeps full safe.
    level_d = wbin_d - rbin;
    // Full: the pointers match in address bits but differ in wrap bit. In
    // Gray code that means the top two bits are inverted.
    full_d  = (wgray_d == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
    afull_d = (level_d >= AF_TH);
    // A set and a clear at the same edge: the set takes priority.
    ovf_d   = (WINC & full_q) | (ovf_q & ~OVF_CLR);
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_EN          = w_en;
  assign W_ADDRESS     = wbin_q[ADDRESS_BITS-1:0];
  assign W_PTR         = wgray_q;
  assign W_FULL        = full_q;
  assign W_ALMOST_FULL = afull_q;
  assign W_LEVEL       = level_q;
  assign W_OVERFLOW    = ovf_q;

endmodule
